icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped instruction cache between the instruction-fetch stage (upstream) and the memory controller (downstream).
- Hits return the 32-bit instruction word one cycle after the request is accepted.
- A miss issues a single 16-byte line fill to the memory controller, installs the returned 128-bit line, then answers the fetcher.
- A rollback input drops a pending answer without aborting the fill already in flight.

Parameters:
- IDX_BITS, 6, index width; line count = 2**IDX_BITS; tag = addr[31:4+IDX_BITS]
- LINE_BYTES, 16, fixed line size; not overridable, must match the memory controller line width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = stall, all state held
- ic_rb  in  1  rollback/redirect from the fetch/ROB side
- if_valid  in  1  fetch request; held with if_pc stable until if_done or ic_rb
- if_pc  in  32  fetch address; bits [1:0] are zero
- if_done  out  1  one-cycle pulse: if_inst is valid
- if_inst  out  32  instruction word
- mc_fc_valid  out  1  line fill request to the memory controller
- mc_fc_addr  out  32  fill address, line-aligned ({pc[31:4],4'b0})
- mc_fc_done  in  1  one-cycle pulse from the memory controller: line ready
- mc_fc_line  in  128  filled line; byte i at bits [8i+7:8i]

Behaviour:
- Storage arrays:
  - valid bit per line, cleared on reset
  - tag array and data array, not reset
- Word select:
  - word k of a line = line[32k+31:32k], with k = pc[3:2] (little-endian)
  - index = pc[3+IDX_BITS:4]
- if_done is cleared every cycle by default, including stall cycles. It is asserted only by the transitions below.
- Reset: state=IDLE, all valid bits 0, if_done=0, if_inst=0, mc_fc_valid=0, mc_fc_addr=0, discard=0.
  - Reset mid-fill: mc_fc_valid drops the next cycle. The memory controller shares rst; no line is installed.
- Stall (rdy=0): no state, array or output change, except if_done dropping to 0. Requests are not accepted.
- IDLE (rdy=1):
  - Requests are ignored when ic_rb=1 or if_done=1. The if_done rule prevents a duplicate response before the fetcher advances.
  - Otherwise, with if_valid=1, tag lookup is combinational on if_pc:
  - Hit: next cycle if_done=1, if_inst=selected word; stay IDLE. Latency 1 cycle; max throughput 1 hit per 2 cycles.
  - Miss: next cycle mc_fc_valid=1, mc_fc_addr=line-aligned pc; latch pend_pc; discard=0; go WAIT.
- WAIT (rdy=1):
  - mc_fc_valid and mc_fc_addr held; if_valid/if_pc ignored.
  - ic_rb=1 sets discard=1. The fill is never aborted, because the memory controller cannot cancel fetches.
  - On mc_fc_done=1:
    - mc_fc_valid<=0 in the same edge, so the memory controller sees valid low, or done high, and never relaunches.
    - Write data[idx]=mc_fc_line, tag[idx]=pend tag, valid[idx]=1.
    - If discard=0 and ic_rb=0: if_done=1, if_inst=word pend_pc[3:2] of mc_fc_line.
    - If discard=1 or ic_rb=1 in that cycle: line installed, no if_done.
    - Clear discard; go IDLE.
- Conflict replacement: a fill always overwrites the indexed line (no associativity, no write path from stores).
- mc_fc_done while IDLE is ignored.
- One outstanding fill at most.

Test Plan:
- Reset then if_valid=1, if_pc=0x00000104:
  - mc_fc_valid=1, mc_fc_addr=0x00000100 one cycle later.
  - mc_fc_done with line=0x33221100_77665544_BBAA9988_FFEEDDCC → if_done pulse with if_inst=0xBBAA9988, valid[16]=1.
- After the previous fill, request pc=0x0000010C:
  - if_done=1 exactly one cycle after acceptance, if_inst=0x33221100, mc_fc_valid stays 0.
  - if_valid still high in the if_done cycle produces no second pulse.
- Conflict, IDX_BITS=6: fill 0x00000100, then request 0x00000500 (same index, different tag):
  - miss, mc_fc_addr=0x00000500.
  - Re-request 0x00000100 → misses again.
- ic_rb=1 two cycles into WAIT, then mc_fc_done:
  - no if_done.
  - A subsequent request to the same line hits in 1 cycle.
- rdy=0 for 3 cycles during a hit-accept or WAIT:
  - outputs frozen, mc_fc_valid stays 1.
  - mc_fc_done arriving after rdy=1 completes normally.
- rst asserted in WAIT:
  - mc_fc_valid=0 next cycle, all valid bits 0.
  - The previously hit address 0x0000010C now misses.

Source files
------------

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with single-line fill and rollback discard
// Hits answer one cycle after acceptance; misses fetch a 16-byte line, install it, then answer.
module icache #(
   parameter int IDX_BITS = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         ic_rb,
   input  logic         if_valid,
   input  logic [31:0]  if_pc,
   output logic         if_done,
   output logic [31:0]  if_inst,
   output logic         mc_fc_valid,
   output logic [31:0]  mc_fc_addr,
   input  logic         mc_fc_done,
   input  logic [127:0] mc_fc_line
);

   localparam int LINE_BYTES = 16;
   localparam int OFF_BITS   = $clog2(LINE_BYTES);
   localparam int LINES      = 2 ** IDX_BITS;
   localparam int TAG_BITS   = 32 - OFF_BITS - IDX_BITS;
   localparam int LINE_W     = 8 * LINE_BYTES;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_e;

   state_e              state_q;
   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [LINE_W-1:0]   data_q [LINES];
   logic [31:0]         pend_pc_q;
   logic                discard_q;
   logic                if_done_q;
   logic [31:0]         if_inst_q;
   logic                mc_fc_valid_q;
   logic [31:0]         mc_fc_addr_q;

   logic [IDX_BITS-1:0] req_idx;
   logic [TAG_BITS-1:0] req_tag;
   logic [IDX_BITS-1:0] pend_idx;
   logic [TAG_BITS-1:0] pend_tag;
   logic                hit;
   logic                accept;
   logic                fill_fire;
   logic [31:0]         hit_word;
   logic [31:0]         fill_word;

   function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line, input logic [1:0] k);
      return line[{k, 5'b0} +: 32];
   endfunction

   assign req_idx  = if_pc[OFF_BITS +: IDX_BITS];
   assign req_tag  = if_pc[31 -: TAG_BITS];
   assign pend_idx = pend_pc_q[OFF_BITS +: IDX_BITS];
   assign pend_tag = pend_pc_q[31 -: TAG_BITS];

   assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign hit_word  = word_of(data_q[req_idx], if_pc[3:2]);
   assign fill_word = word_of(mc_fc_line, pend_pc_q[3:2]);

   // if_done gates acceptance so a still-high if_valid is not answered twice.
   assign accept    = (state_q == S_IDLE) && rdy && if_valid && !ic_rb && !if_done_q;
   assign fill_fire = (state_q == S_WAIT) && rdy && mc_fc_done;

   // Tag and data arrays carry no reset; valid_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (!rst && fill_fire) begin
         data_q[pend_idx] <= mc_fc_line;
         tag_q[pend_idx]  <= pend_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         valid_q       <= '0;
         pend_pc_q     <= '0;
         discard_q     <= 1'b0;
         if_done_q     <= 1'b0;
         if_inst_q     <= '0;
         mc_fc_valid_q <= 1'b0;
         mc_fc_addr_q  <= '0;
      end else begin
         if_done_q <= 1'b0;
         if (rdy) begin
            case (state_q)
               S_IDLE: begin
                  if (accept) begin
                     if (hit) begin
                        if_done_q <= 1'b1;
                        if_inst_q <= hit_word;
                     end else begin
                        mc_fc_valid_q <= 1'b1;
                        mc_fc_addr_q  <= {if_pc[31:OFF_BITS], {OFF_BITS{1'b0}}};
                        pend_pc_q     <= if_pc;
                        discard_q     <= 1'b0;
                        state_q       <= S_WAIT;
                     end
                  end
               end
               S_WAIT: begin
                  if (mc_fc_done) begin
                     // Drop valid on the same edge so the controller never relaunches.
                     mc_fc_valid_q     <= 1'b0;
                     valid_q[pend_idx] <= 1'b1;
                     if (!discard_q && !ic_rb) begin
                        if_done_q <= 1'b1;
                        if_inst_q <= fill_word;
                     end
                     discard_q <= 1'b0;
                     state_q   <= S_IDLE;
                  end else if (ic_rb) begin
                     discard_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign if_done     = if_done_q;
   assign if_inst     = if_inst_q;
   assign mc_fc_valid = mc_fc_valid_q;
   assign mc_fc_addr  = mc_fc_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache
// Expected instruction words are queued when a fetch is driven and popped when if_done appears.
module tb_icache;

   logic         clk;
   logic         rst;
   logic         rdy;
   logic         ic_rb;
   logic         if_valid;
   logic [31:0]  if_pc;
   logic         if_done;
   logic [31:0]  if_inst;
   logic         mc_fc_valid;
   logic [31:0]  mc_fc_addr;
   logic         mc_fc_done;
   logic [127:0] mc_fc_line;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   localparam logic [127:0] L1 = 128'h33221100_77665544_BBAA9988_FFEEDDCC;

   icache #(.IDX_BITS(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .ic_rb       (ic_rb),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_done     (if_done),
      .if_inst     (if_inst),
      .mc_fc_valid (mc_fc_valid),
      .mc_fc_addr  (mc_fc_addr),
      .mc_fc_done  (mc_fc_done),
      .mc_fc_line  (mc_fc_line)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory contents: the reference line at 0x100, an address-derived pattern elsewhere.
   function automatic logic [127:0] mem_line(input logic [31:0] a);
      if (a == 32'h0000_0100) return L1;
      return {a ^ 32'hA5A5_0000, a ^ 32'h5A5A_0000, ~a, a + 32'h1234_5678};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      logic [127:0] ln;
      ln = mem_line({pc[31:4], 4'b0});
      return ln[pc[3:2]*32 +: 32];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one complete fetch; a miss is served by the memory model after lat cycles.
   task automatic fetch(input logic [31:0] pc, input int lat, output bit missed,
                        output bit done, output logic [31:0] inst, output logic [31:0] fill_addr);
      if_pc = pc;
      if_valid = 1'b1;
      step();
      missed    = mc_fc_valid;
      fill_addr = mc_fc_addr;
      done      = if_done;
      inst      = if_inst;
      if (missed) begin
         repeat (lat) step();
         mc_fc_line = mem_line(fill_addr);
         mc_fc_done = 1'b1;
         step();
         mc_fc_done = 1'b0;
         done = if_done;
         inst = if_inst;
      end
      if_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      checks++;
      if (if_done !== 1'b0 || if_inst !== 32'h0 || mc_fc_valid !== 1'b0 || mc_fc_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset: if_done=%b if_inst=%h mc_fc_valid=%b mc_fc_addr=%h expected all zero",
                  if_done, if_inst, mc_fc_valid, mc_fc_addr);
      end
   endtask

   task automatic test_miss_fill();
      logic [31:0] exp;
      exp_q.push_back(32'hBBAA9988);
      if_pc = 32'h0000_0104;
      if_valid = 1'b1;
      step();
      checks++;
      if (mc_fc_valid !== 1'b1 || mc_fc_addr !== 32'h0000_0100 || if_done !== 1'b0) begin
         errors++;
         $display("FAIL miss_req: mc_fc_valid=%b mc_fc_addr=%h if_done=%b expected 1/00000100/0",
                  mc_fc_valid, mc_fc_addr, if_done);
      end
      repeat (2) step();
      checks++;
      if (mc_fc_valid !== 1'b1 || mc_fc_addr !== 32'h0000_0100) begin
         errors++;
         $display("FAIL miss_hold: mc_fc_valid=%b mc_fc_addr=%h expected 1/00000100", mc_fc_valid, mc_fc_addr);
      end
      mc_fc_line = L1;
      mc_fc_done = 1'b1;
      step();
      mc_fc_done = 1'b0;
      if_valid = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (if_done !== 1'b1 || if_inst !== exp || mc_fc_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_answer: if_done=%b if_inst=%h mc_fc_valid=%b expected 1/%h/0",
                  if_done, if_inst, mc_fc_valid, exp);
      end
      step();
   endtask

   task automatic test_hit();
      logic [31:0] exp;
      logic [31:0] pcs[3] = '{32'h0000_0100, 32'h0000_0108, 32'h0000_0104};
      bit m, d;
      logic [31:0] inst, fa;
      exp_q.push_back(32'h33221100);
      if_pc = 32'h0000_010C;
      if_valid = 1'b1;
      step();
      exp = exp_q.pop_front();
      checks++;
      if (if_done !== 1'b1 || if_inst !== exp || mc_fc_valid !== 1'b0) begin
         errors++;
         $display("FAIL hit_10c: if_done=%b if_inst=%h mc_fc_valid=%b expected 1/%h/0",
                  if_done, if_inst, mc_fc_valid, exp);
      end
      step();
      checks++;
      if (if_done !== 1'b0) begin
         errors++;
         $display("FAIL no_dup_pulse: if_done=%b expected 0", if_done);
      end
      if_valid = 1'b0;
      step();
      foreach (pcs[i]) begin
         exp_q.push_back(mem_word(pcs[i]));
         fetch(pcs[i], 0, m, d, inst, fa);
         exp = exp_q.pop_front();
         checks++;
         if (m !== 1'b0 || d !== 1'b1 || inst !== exp) begin
            errors++;
            $display("FAIL hit_word %h: missed=%b done=%b inst=%h expected 0/1/%h", pcs[i], m, d, inst, exp);
         end
      end
   endtask

   task automatic test_conflict();
      bit m, d;
      logic [31:0] inst, fa, exp;
      exp_q.push_back(mem_word(32'h0000_0500));
      fetch(32'h0000_0500, 1, m, d, inst, fa);
      exp = exp_q.pop_front();
      checks++;
      if (m !== 1'b1 || fa !== 32'h0000_0500 || d !== 1'b1 || inst !== exp) begin
         errors++;
         $display("FAIL conflict_500: missed=%b addr=%h done=%b inst=%h expected 1/00000500/1/%h",
                  m, fa, d, inst, exp);
      end
      exp_q.push_back(mem_word(32'h0000_0100));
      fetch(32'h0000_0100, 2, m, d, inst, fa);
      exp = exp_q.pop_front();
      checks++;
      if (m !== 1'b1 || fa !== 32'h0000_0100 || d !== 1'b1 || inst !== exp) begin
         errors++;
         $display("FAIL conflict_100: missed=%b addr=%h done=%b inst=%h expected 1/00000100/1/%h",
                  m, fa, d, inst, exp);
      end
   endtask

   task automatic test_rollback();
      bit m, d;
      logic [31:0] inst, fa, exp;
      logic [31:0] pcs[2] = '{32'h0000_2008, 32'h0000_3004};
      foreach (pcs[i]) begin
         if_pc = pcs[i];
         if_valid = 1'b1;
         step();
         if (i == 0) begin
            step();
            ic_rb = 1'b1;
            if_valid = 1'b0;
            step();
            ic_rb = 1'b0;
            step();
         end else begin
            ic_rb = 1'b1;
            if_valid = 1'b0;
         end
         mc_fc_line = mem_line({pcs[i][31:4], 4'b0});
         mc_fc_done = 1'b1;
         step();
         mc_fc_done = 1'b0;
         ic_rb = 1'b0;
         checks++;
         if (if_done !== 1'b0 || mc_fc_valid !== 1'b0) begin
            errors++;
            $display("FAIL rollback_drop %h: if_done=%b mc_fc_valid=%b expected 0/0", pcs[i], if_done, mc_fc_valid);
         end
         step();
         exp_q.push_back(mem_word(pcs[i]));
         fetch(pcs[i], 0, m, d, inst, fa);
         exp = exp_q.pop_front();
         checks++;
         if (m !== 1'b0 || d !== 1'b1 || inst !== exp) begin
            errors++;
            $display("FAIL rollback_hit %h: missed=%b done=%b inst=%h expected 0/1/%h", pcs[i], m, d, inst, exp);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp;
      int bad;
      exp_q.push_back(mem_word(32'h0000_0104));
      if_pc = 32'h0000_0104;
      if_valid = 1'b1;
      step();
      exp = exp_q.pop_front();
      checks++;
      if (if_done !== 1'b1 || if_inst !== exp) begin
         errors++;
         $display("FAIL stall_hit: if_done=%b if_inst=%h expected 1/%h", if_done, if_inst, exp);
      end
      rdy = 1'b0;
      bad = 0;
      repeat (3) begin
         step();
         if (if_done !== 1'b0 || if_inst !== exp || mc_fc_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_idle_frozen: %0d bad cycles, last if_done=%b if_inst=%h expected 0/%h",
                  bad, if_done, if_inst, exp);
      end
      if_valid = 1'b0;
      rdy = 1'b1;
      step();
      exp_q.push_back(mem_word(32'h0000_4008));
      if_pc = 32'h0000_4008;
      if_valid = 1'b1;
      step();
      if_valid = 1'b0;
      rdy = 1'b0;
      bad = 0;
      repeat (3) begin
         step();
         if (mc_fc_valid !== 1'b1 || mc_fc_addr !== 32'h0000_4000 || if_done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_wait_frozen: %0d bad cycles, mc_fc_valid=%b mc_fc_addr=%h expected 1/00004000",
                  bad, mc_fc_valid, mc_fc_addr);
      end
      rdy = 1'b1;
      step();
      mc_fc_line = mem_line(32'h0000_4000);
      mc_fc_done = 1'b1;
      step();
      mc_fc_done = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (if_done !== 1'b1 || if_inst !== exp || mc_fc_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_fill: if_done=%b if_inst=%h mc_fc_valid=%b expected 1/%h/0",
                  if_done, if_inst, mc_fc_valid, exp);
      end
      step();
   endtask

   task automatic test_reset_mid_fill();
      bit m, d;
      logic [31:0] inst, fa, exp;
      mc_fc_line = mem_line(32'h0000_7000);
      mc_fc_done = 1'b1;
      step();
      mc_fc_done = 1'b0;
      checks++;
      if (if_done !== 1'b0 || mc_fc_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_done_ignored: if_done=%b mc_fc_valid=%b expected 0/0", if_done, mc_fc_valid);
      end
      if_pc = 32'h0000_6000;
      if_valid = 1'b1;
      step();
      if_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (mc_fc_valid !== 1'b0 || mc_fc_addr !== 32'h0 || if_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fill: mc_fc_valid=%b mc_fc_addr=%h if_done=%b expected 0/0/0",
                  mc_fc_valid, mc_fc_addr, if_done);
      end
      step();
      exp_q.push_back(mem_word(32'h0000_010C));
      fetch(32'h0000_010C, 1, m, d, inst, fa);
      exp = exp_q.pop_front();
      checks++;
      if (m !== 1'b1 || fa !== 32'h0000_0100 || d !== 1'b1 || inst !== exp) begin
         errors++;
         $display("FAIL post_reset_miss: missed=%b addr=%h done=%b inst=%h expected 1/00000100/1/%h",
                  m, fa, d, inst, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      ic_rb = 1'b0;
      if_valid = 1'b0;
      if_pc = 32'h0;
      mc_fc_done = 1'b0;
      mc_fc_line = '0;
      test_reset();
      test_miss_fill();
      test_hit();
      test_conflict();
      test_rollback();
      test_stall();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
